// File: rtl/ahb_txn_queue.sv
// ahb_txn_queue: command/response staging in front of the AHB master bridge.
// Requester commands are buffered in a command FIFO and presented one per
// handshake to the master. Read issue is gated by credits so that the
// response FIFO always has room for read data, which the master cannot stall.
//
// Handshakes: a transfer happens on a cycle where valid & ready are both 1
// at the rising clock edge. A valid side never depends combinationally on
// its own ready input, and holds its payload stable until the transfer.
// i_rd_valid is a single-cycle pulse with no ready (always accepted).
module ahb_txn_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR       = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int RSP_DEPTH  = 4,
  parameter int TAG_W      = 4
) (
  input  logic                         i_clk_ahb,
  input  logic                         i_rst_ahb,
  input  logic                         i_req_valid,
  output logic                         o_req_ready,
  input  logic [ADDR-1:0]              i_req_addr,
  input  logic [DATA_WIDTH-1:0]        i_req_wdata,
  input  logic                         i_req_rd0_wr1,
  input  logic [TAG_W-1:0]             i_req_tag,
  output logic                         o_valid,
  output logic [ADDR-1:0]              o_addr,
  output logic [DATA_WIDTH-1:0]        o_wr_data,
  output logic                         o_rd0_wr1,
  input  logic                         i_ready,
  input  logic [DATA_WIDTH-1:0]        i_rd_data,
  input  logic                         i_rd_valid,
  output logic                         o_rsp_valid,
  output logic [DATA_WIDTH-1:0]        o_rsp_data,
  output logic [TAG_W-1:0]             o_rsp_tag,
  input  logic                         i_rsp_ready,
  output logic [$clog2(CMD_DEPTH):0]   o_cmd_count,
  output logic                         o_err_unexp_rd
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int CW  = ADDR + DATA_WIDTH + 1 + TAG_W;
  localparam int RW  = DATA_WIDTH + TAG_W;
  localparam logic [CAW:0] CMD_FULL = (CAW+1)'(CMD_DEPTH);
  localparam logic [RAW:0] RSP_FULL = (RAW+1)'(RSP_DEPTH);

  // Command FIFO storage and control
  logic [CW-1:0]  cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [CAW:0]   cmd_cnt;

  // Outstanding-read tag FIFO
  logic [TAG_W-1:0] tag_mem [RSP_DEPTH];
  logic [RAW-1:0]   tag_wr_ptr, tag_rd_ptr;
  logic [RAW:0]     tag_cnt;

  // Response FIFO ({data, tag})
  logic [RW-1:0]  rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
  logic [RAW:0]   rsp_cnt;

  // Read credits: free response slots not yet claimed by an issued read
  logic [RAW:0]   credits;
  logic           err_q;

  logic [ADDR-1:0]       head_addr;
  logic [DATA_WIDTH-1:0] head_wdata;
  logic                  head_wr;
  logic [TAG_W-1:0]      head_tag;
  logic                  cmd_not_full, issue_ok;
  logic                  cmd_push, cmd_pop, rd_issue;
  logic                  tag_pop, rsp_push, rsp_pop, unexp_rd;

  assign {head_addr, head_wdata, head_wr, head_tag} = cmd_mem[cmd_rd_ptr];

  assign cmd_not_full = (cmd_cnt != CMD_FULL);
  // A read at the head waits for a credit and blocks everything behind it.
  assign issue_ok     = (cmd_cnt != '0) && (head_wr || (credits != '0));
  assign cmd_push     = i_req_valid & cmd_not_full;
  assign cmd_pop      = issue_ok & i_ready;
  assign rd_issue     = cmd_pop & ~head_wr;
  assign tag_pop      = i_rd_valid & (tag_cnt != '0);
  assign rsp_push     = tag_pop;
  assign unexp_rd     = i_rd_valid & (tag_cnt == '0);
  assign rsp_pop      = (rsp_cnt != '0) & i_rsp_ready;

  // Outputs are forced low for as long as reset is held.
  assign o_req_ready    = ~i_rst_ahb & cmd_not_full;
  assign o_valid        = ~i_rst_ahb & issue_ok;
  assign o_addr         = i_rst_ahb ? '0 : head_addr;
  assign o_wr_data      = i_rst_ahb ? '0 : head_wdata;
  assign o_rd0_wr1      = ~i_rst_ahb & head_wr;
  assign o_rsp_valid    = ~i_rst_ahb & (rsp_cnt != '0);
  assign o_rsp_data     = i_rst_ahb ? '0 : rsp_mem[rsp_rd_ptr][RW-1:TAG_W];
  assign o_rsp_tag      = i_rst_ahb ? '0 : rsp_mem[rsp_rd_ptr][TAG_W-1:0];
  assign o_cmd_count    = i_rst_ahb ? '0 : cmd_cnt;
  assign o_err_unexp_rd = ~i_rst_ahb & err_q;

  // Storage arrays: written on push only, contents are don't-care when empty
  always_ff @(posedge i_clk_ahb) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {i_req_addr, i_req_wdata, i_req_rd0_wr1, i_req_tag};
    if (rd_issue) tag_mem[tag_wr_ptr] <= head_tag;
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= {i_rd_data, tag_mem[tag_rd_ptr]};
  end

  // Command FIFO pointers and occupancy
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_cnt    <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CAW'(1);
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + CAW'(1);
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_cnt <= cmd_cnt + (CAW+1)'(1);
        2'b01:   cmd_cnt <= cmd_cnt - (CAW+1)'(1);
        default: cmd_cnt <= cmd_cnt;
      endcase
    end
  end

  // Outstanding-tag FIFO: pushed on read issue, popped on returning data
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (rd_issue) tag_wr_ptr <= tag_wr_ptr + RAW'(1);
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + RAW'(1);
      case ({rd_issue, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + (RAW+1)'(1);
        2'b01:   tag_cnt <= tag_cnt - (RAW+1)'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Response FIFO pointers and occupancy
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_cnt    <= '0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RAW'(1);
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RAW'(1);
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_cnt <= rsp_cnt + (RAW+1)'(1);
        2'b01:   rsp_cnt <= rsp_cnt - (RAW+1)'(1);
        default: rsp_cnt <= rsp_cnt;
      endcase
    end
  end

  // Credits: taken by a read issue, returned when its response is consumed
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb) begin
      credits <= RSP_FULL;
    end else begin
      case ({rd_issue, rsp_pop})
        2'b10:   credits <= credits - (RAW+1)'(1);
        2'b01:   credits <= credits + (RAW+1)'(1);
        default: credits <= credits;
      endcase
    end
  end

  // Sticky flag for read data that arrived with no read outstanding
  always_ff @(posedge i_clk_ahb or posedge i_rst_ahb) begin
    if (i_rst_ahb)     err_q <= 1'b0;
    else if (unexp_rd) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_ahb_txn_queue.sv
// Directed bench for ahb_txn_queue: cycle vectors of inputs with expected
// outputs, plus hand-written reset sequences.
module tb_ahb_txn_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_wr;
  logic [3:0]  req_tag;
  logic        valid;
  logic [31:0] addr, wr_data;
  logic        rd0_wr1;
  logic        ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        rsp_ready;
  logic [2:0]  cmd_count;
  logic        err_unexp;

  int errors = 0;
  int checks = 0;

  ahb_txn_queue dut (
    .i_clk_ahb      (clk),
    .i_rst_ahb      (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .i_req_rd0_wr1  (req_wr),
    .i_req_tag      (req_tag),
    .o_valid        (valid),
    .o_addr         (addr),
    .o_wr_data      (wr_data),
    .o_rd0_wr1      (rd0_wr1),
    .i_ready        (ready),
    .i_rd_data      (rd_data),
    .i_rd_valid     (rd_valid),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_tag      (rsp_tag),
    .i_rsp_ready    (rsp_ready),
    .o_cmd_count    (cmd_count),
    .o_err_unexp_rd (err_unexp)
  );

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic        req_valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [3:0]  tag;
    logic        rdy;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rsp_ready;
    logic        x_req_ready;
    logic        x_valid;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_wr;
    logic        x_rsp_valid;
    logic [31:0] x_rsp_data;
    logic [3:0]  x_rsp_tag;
    logic [2:0]  x_count;
    logic        x_err;
  } vec_t;

  vec_t vecs[$];
  vec_t cur;

  // Stage the inputs of one cycle vector
  function automatic void vi(input logic rv, input logic [31:0] a, input logic [31:0] d,
                             input logic w, input logic [3:0] t, input logic rdy,
                             input logic rdv, input logic [31:0] rdd, input logic rspr);
    cur.req_valid = rv; cur.addr = a; cur.wdata = d; cur.wr = w; cur.tag = t;
    cur.rdy = rdy; cur.rd_valid = rdv; cur.rd_data = rdd; cur.rsp_ready = rspr;
  endfunction

  // Add the expected outputs of that cycle and queue the vector
  function automatic void ve(input logic rr, input logic v, input logic [31:0] a,
                             input logic [31:0] d, input logic w, input logic rspv,
                             input logic [31:0] rspd, input logic [3:0] rspt,
                             input logic [2:0] cnt, input logic e);
    cur.x_req_ready = rr; cur.x_valid = v; cur.x_addr = a; cur.x_wdata = d; cur.x_wr = w;
    cur.x_rsp_valid = rspv; cur.x_rsp_data = rspd; cur.x_rsp_tag = rspt;
    cur.x_count = cnt; cur.x_err = e;
    vecs.push_back(cur);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = 0; req_addr = '0; req_wdata = '0; req_wr = 0; req_tag = '0;
    ready = 0; rd_valid = 0; rd_data = '0; rsp_ready = 0;
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({pfx, "_valid"},     64'(valid),     64'd0);
    chk({pfx, "_addr"},      64'(addr),      64'd0);
    chk({pfx, "_wr_data"},   64'(wr_data),   64'd0);
    chk({pfx, "_rd0_wr1"},   64'(rd0_wr1),   64'd0);
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({pfx, "_rsp_data"},  64'(rsp_data),  64'd0);
    chk({pfx, "_rsp_tag"},   64'(rsp_tag),   64'd0);
    chk({pfx, "_count"},     64'(cmd_count), 64'd0);
    chk({pfx, "_err"},       64'(err_unexp), 64'd0);
  endtask

  task automatic chk_idle(input string pfx);
    chk({pfx, "_req_ready"}, 64'(req_ready), 64'd1);
    chk({pfx, "_valid"},     64'(valid),     64'd0);
    chk({pfx, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({pfx, "_count"},     64'(cmd_count), 64'd0);
    chk({pfx, "_err"},       64'(err_unexp), 64'd0);
  endtask

  task automatic cycle_in(input logic rv, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [3:0] t, input logic rdy,
                          input logic rdv, input logic [31:0] rdd);
    @(posedge clk); #1;
    req_valid = rv; req_addr = a; req_wdata = d; req_wr = w; req_tag = t;
    ready = rdy; rd_valid = rdv; rd_data = rdd; rsp_ready = 0;
  endtask

  initial begin
    logic ok;
    vec_t v;

    // ---- group A: four writes, master always ready
    vi(1, 'h10, 'hA0, 1, 0, 1, 0, 0, 0); ve(1, 0, 0,     0,     0, 0, 0, 0, 0, 0);
    vi(1, 'h14, 'hA1, 1, 0, 1, 0, 0, 0); ve(1, 1, 'h10, 'hA0, 1, 0, 0, 0, 1, 0);
    vi(1, 'h18, 'hA2, 1, 0, 1, 0, 0, 0); ve(1, 1, 'h14, 'hA1, 1, 0, 0, 0, 1, 0);
    vi(1, 'h1C, 'hA3, 1, 0, 1, 0, 0, 0); ve(1, 1, 'h18, 'hA2, 1, 0, 0, 0, 1, 0);
    vi(0, 0,    0,    0, 0, 1, 0, 0, 0); ve(1, 1, 'h1C, 'hA3, 1, 0, 0, 0, 1, 0);
    vi(0, 0,    0,    0, 0, 1, 0, 0, 0); ve(1, 0, 0,     0,     0, 0, 0, 0, 0, 0);
    // ---- group B: fill with master stalled, push+pop at count 3, drain
    vi(1, 'h20, 'hB0, 1, 0, 0, 0, 0, 0); ve(1, 0, 0,     0,     0, 0, 0, 0, 0, 0);
    vi(1, 'h24, 'hB1, 1, 0, 0, 0, 0, 0); ve(1, 1, 'h20, 'hB0, 1, 0, 0, 0, 1, 0);
    vi(1, 'h28, 'hB2, 1, 0, 0, 0, 0, 0); ve(1, 1, 'h20, 'hB0, 1, 0, 0, 0, 2, 0);
    vi(1, 'h2C, 'hB3, 1, 0, 0, 0, 0, 0); ve(1, 1, 'h20, 'hB0, 1, 0, 0, 0, 3, 0);
    vi(1, 'h30, 'hB4, 1, 0, 0, 0, 0, 0); ve(0, 1, 'h20, 'hB0, 1, 0, 0, 0, 4, 0);
    vi(1, 'h30, 'hB4, 1, 0, 1, 0, 0, 0); ve(0, 1, 'h20, 'hB0, 1, 0, 0, 0, 4, 0);
    vi(1, 'h30, 'hB4, 1, 0, 1, 0, 0, 0); ve(1, 1, 'h24, 'hB1, 1, 0, 0, 0, 3, 0);
    vi(0, 0,    0,    0, 0, 0, 0, 0, 0); ve(1, 1, 'h28, 'hB2, 1, 0, 0, 0, 3, 0);
    vi(0, 0,    0,    0, 0, 1, 0, 0, 0); ve(1, 1, 'h28, 'hB2, 1, 0, 0, 0, 3, 0);
    vi(0, 0,    0,    0, 0, 1, 0, 0, 0); ve(1, 1, 'h2C, 'hB3, 1, 0, 0, 0, 2, 0);
    vi(0, 0,    0,    0, 0, 1, 0, 0, 0); ve(1, 1, 'h30, 'hB4, 1, 0, 0, 0, 1, 0);
    vi(0, 0,    0,    0, 0, 0, 0, 0, 0); ve(1, 0, 0,     0,     0, 0, 0, 0, 0, 0);
    // ---- group C: five reads, credit exhaustion, responses in order
    vi(1, 'h40, 0, 0, 1, 1, 0, 0,     0); ve(1, 0, 0,     0, 0, 0, 0,     0, 0, 0);
    vi(1, 'h44, 0, 0, 2, 1, 0, 0,     0); ve(1, 1, 'h40, 0, 0, 0, 0,     0, 1, 0);
    vi(1, 'h48, 0, 0, 3, 1, 1, 'hD1, 0); ve(1, 1, 'h44, 0, 0, 0, 0,     0, 1, 0);
    vi(1, 'h4C, 0, 0, 4, 1, 1, 'hD2, 0); ve(1, 1, 'h48, 0, 0, 1, 'hD1, 1, 1, 0);
    vi(1, 'h50, 0, 0, 5, 1, 1, 'hD3, 0); ve(1, 1, 'h4C, 0, 0, 1, 'hD1, 1, 1, 0);
    vi(0, 0,    0, 0, 0, 1, 1, 'hD4, 0); ve(1, 0, 0,     0, 0, 1, 'hD1, 1, 1, 0);
    vi(0, 0,    0, 0, 0, 1, 0, 0,     0); ve(1, 0, 0,     0, 0, 1, 'hD1, 1, 1, 0);
    vi(0, 0,    0, 0, 0, 1, 0, 0,     1); ve(1, 0, 0,     0, 0, 1, 'hD1, 1, 1, 0);
    vi(0, 0,    0, 0, 0, 1, 0, 0,     0); ve(1, 1, 'h50, 0, 0, 1, 'hD2, 2, 1, 0);
    vi(0, 0,    0, 0, 0, 1, 1, 'hD5, 1); ve(1, 0, 0,     0, 0, 1, 'hD2, 2, 0, 0);
    vi(0, 0,    0, 0, 0, 0, 0, 0,     1); ve(1, 0, 0,     0, 0, 1, 'hD3, 3, 0, 0);
    vi(0, 0,    0, 0, 0, 0, 0, 0,     1); ve(1, 0, 0,     0, 0, 1, 'hD4, 4, 0, 0);
    vi(0, 0,    0, 0, 0, 0, 0, 0,     1); ve(1, 0, 0,     0, 0, 1, 'hD5, 5, 0, 0);
    vi(0, 0,    0, 0, 0, 0, 0, 0,     0); ve(1, 0, 0,     0, 0, 0, 0,     0, 0, 0);
    // ---- group D: read(3), write, read(7) in order
    vi(1, 'h60, 0,     0, 3, 1, 0, 0,     0); ve(1, 0, 0,     0,     0, 0, 0,     0, 0, 0);
    vi(1, 'h64, 'hC1, 1, 0, 1, 0, 0,     0); ve(1, 1, 'h60, 0,     0, 0, 0,     0, 1, 0);
    vi(1, 'h68, 0,     0, 7, 1, 1, 'hE3, 0); ve(1, 1, 'h64, 'hC1, 1, 0, 0,     0, 1, 0);
    vi(0, 0,    0,     0, 0, 1, 0, 0,     0); ve(1, 1, 'h68, 0,     0, 1, 'hE3, 3, 1, 0);
    vi(0, 0,    0,     0, 0, 1, 1, 'hE7, 1); ve(1, 0, 0,     0,     0, 1, 'hE3, 3, 0, 0);
    vi(0, 0,    0,     0, 0, 0, 0, 0,     1); ve(1, 0, 0,     0,     0, 1, 'hE7, 7, 0, 0);
    vi(0, 0,    0,     0, 0, 0, 0, 0,     0); ve(1, 0, 0,     0,     0, 0, 0,     0, 0, 0);
    // ---- group E: unexpected read data sets the sticky flag
    vi(0, 0, 0, 0, 0, 0, 1, 'hBAD, 0); ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vi(0, 0, 0, 0, 0, 0, 0, 0,     0); ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    vi(0, 0, 0, 0, 0, 1, 0, 0,     1); ve(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // ---- reset at time zero
    rst = 1'b1;
    drive_idle();
    #3;
    chk_all_zero("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("idle");

    // ---- table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      req_valid = v.req_valid; req_addr = v.addr; req_wdata = v.wdata; req_wr = v.wr;
      req_tag = v.tag; ready = v.rdy; rd_valid = v.rd_valid; rd_data = v.rd_data;
      rsp_ready = v.rsp_ready;
      @(negedge clk);
      ok = (req_ready === v.x_req_ready) && (valid === v.x_valid) &&
           (cmd_count === v.x_count) && (rsp_valid === v.x_rsp_valid) &&
           (err_unexp === v.x_err);
      if (v.x_valid)
        ok = ok && (addr === v.x_addr) && (wr_data === v.x_wdata) && (rd0_wr1 === v.x_wr);
      if (v.x_rsp_valid)
        ok = ok && (rsp_data === v.x_rsp_data) && (rsp_tag === v.x_rsp_tag);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d: got rr=%b v=%b a=%h d=%h w=%b rv=%b rd=%h rt=%h c=%0d e=%b expected rr=%b v=%b a=%h d=%h w=%b rv=%b rd=%h rt=%h c=%0d e=%b",
                 i, req_ready, valid, addr, wr_data, rd0_wr1, rsp_valid, rsp_data, rsp_tag,
                 cmd_count, err_unexp, v.x_req_ready, v.x_valid, v.x_addr, v.x_wdata, v.x_wr,
                 v.x_rsp_valid, v.x_rsp_data, v.x_rsp_tag, v.x_count, v.x_err);
      end
    end

    // ---- reset mid-traffic: queued commands, a buffered response, sticky error
    cycle_in(1, 'h70, 0,     0, 9, 1, 0, 0);
    cycle_in(0, 0,    0,     0, 0, 1, 0, 0);
    cycle_in(0, 0,    0,     0, 0, 0, 1, 'hF9);
    cycle_in(1, 'h74, 'hF4, 1, 0, 0, 0, 0);
    cycle_in(1, 'h78, 'hF8, 1, 0, 0, 0, 0);
    cycle_in(0, 0,    0,     0, 0, 0, 0, 0);
    @(negedge clk);
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("pre_rst_rsp_data",  64'(rsp_data),  64'hF9);
    chk("pre_rst_rsp_tag",   64'(rsp_tag),   64'd9);
    chk("pre_rst_count",     64'(cmd_count), 64'd2);
    chk("pre_rst_addr",      64'(addr),      64'h74);
    chk("pre_rst_err",       64'(err_unexp), 64'd1);
    #2;
    req_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_rst");

    // ---- credits restored after reset: a fresh read issues and returns
    cycle_in(1, 'h80, 0, 0, 6, 1, 0, 0);
    cycle_in(0, 0,    0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("post_rst_issue_valid", 64'(valid), 64'd1);
    chk("post_rst_issue_addr",  64'(addr),  64'h80);
    cycle_in(0, 0, 0, 0, 0, 0, 1, 'h66);
    cycle_in(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_rsp_data", 64'(rsp_data), 64'h66);
    chk("post_rst_rsp_tag",  64'(rsp_tag),  64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
